// File: rtl/tank_access_sequencer_if.sv
// Bus between the store requesters and the tank access sequencer.
// master: the requester side (order fetch / operand access).
// slave : the sequencer itself.
// state_dbg carries the sequencer FSM state for observation.
interface tank_access_sequencer_if #(
  parameter int N_TANKS        = 4,
  parameter int WORDS_PER_TANK = 32,
  parameter int WORD_TIME      = 18
);
  localparam int TW = $clog2(N_TANKS);
  localparam int WW = $clog2(WORDS_PER_TANK);
  localparam int PW = $clog2(WORD_TIME);
  localparam int AW = TW + WW;

  logic [1:0]         req;
  logic [1:0]         req_wr;
  logic [2*AW-1:0]    req_addr;
  logic [1:0]         ack;
  logic [1:0]         done;
  logic [N_TANKS-1:0] t_in;
  logic [N_TANKS-1:0] t_out;
  logic [PW-1:0]      pulse_cnt;
  logic [WW-1:0]      minor_cnt;
  logic               busy;
  logic [1:0]         state_dbg;

  modport master (
    output req, req_wr, req_addr,
    input  ack, done, t_in, t_out, pulse_cnt, minor_cnt, busy, state_dbg
  );

  modport slave (
    input  req, req_wr, req_addr,
    output ack, done, t_in, t_out, pulse_cnt, minor_cnt, busy, state_dbg
  );
endinterface

// File: rtl/tank_access_sequencer.sv
// Store access sequencer for a mercury-tank group.
// Keeps circulation timing (pulse within word, minor cycle within tank),
// arbitrates order fetch [0] against operand access [1], waits for the
// addressed word slot and opens one tank gate for exactly one word time.
// Optional feature macro: TANK_SEQ_RR_ARB_EN selects round-robin arbitration;
// without it req[0] has fixed priority.
//
// Handshake: req[r] is a level held by the requester until ack[r] pulses
// (one cycle, the cycle after the grant edge). req_addr/req_wr are sampled
// only at that grant edge. done[r] pulses once when the word time is over.
module tank_access_sequencer #(
  parameter int N_TANKS        = 4,
  parameter int WORDS_PER_TANK = 32,
  parameter int WORD_TIME      = 18
) (
  input logic                     clk,
  input logic                     rst,
  tank_access_sequencer_if.slave  bus
);
  localparam int TW = $clog2(N_TANKS);
  localparam int WW = $clog2(WORDS_PER_TANK);
  localparam int PW = $clog2(WORD_TIME);
  localparam int AW = TW + WW;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, XFER = 2'd2, DONE = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [WW-1:0] minor_q, minor_d;
  logic [TW-1:0] tank_q, tank_d;
  logic [WW-1:0] word_q, word_d;
  logic          wr_q, wr_d;
  logic          gnt_q, gnt_d;
  logic [1:0]    ack_q, ack_d;
  logic          pulse_wrap;
  logic          win_next;
  logic          sel;
  logic [AW-1:0] addr_sel;
  logic [N_TANKS-1:0] t_in, t_out;
  logic [1:0]    done;

`ifdef TANK_SEQ_RR_ARB_EN
  logic          last_q, last_d;

  // Round robin: on a tie the requester not granted last time wins.
  always_comb begin
    sel = 1'b0;
    if (bus.req == 2'b11) sel = ~last_q;
    else                  sel = ~bus.req[0];
  end
`else
  // Fixed priority: order fetch always wins.
  always_comb begin
    sel = ~bus.req[0];
  end
`endif

  assign addr_sel = sel ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];

  // Circulation counters; win_next flags that the next cycle opens the target slot.
  always_comb begin
    pulse_wrap = (pulse_q == PW'(WORD_TIME - 1));
    pulse_d    = pulse_wrap ? '0 : pulse_q + PW'(1);
    minor_d    = pulse_wrap ? minor_q + WW'(1) : minor_q;
    win_next   = pulse_wrap && (minor_d == word_q);
  end

  // Next-state logic: grant in IDLE, wait for the slot, one word of transfer, done.
  always_comb begin
    state_d = state_q;
    tank_d  = tank_q;
    word_d  = word_q;
    wr_d    = wr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
`ifdef TANK_SEQ_RR_ARB_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d    = WAIT;
          tank_d     = addr_sel[AW-1:WW];
          word_d     = addr_sel[WW-1:0];
          wr_d       = bus.req_wr[sel];
          gnt_d      = sel;
          ack_d[sel] = 1'b1;
`ifdef TANK_SEQ_RR_ARB_EN
          last_d     = sel;
`endif
        end
      end
      WAIT:    if (win_next) state_d = XFER;
      XFER:    if (pulse_wrap) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gate and completion outputs decoded from the current state.
  always_comb begin
    t_in  = '0;
    t_out = '0;
    done  = '0;
    if (state_q == XFER) begin
      if (wr_q) t_in[tank_q]  = 1'b1;
      else      t_out[tank_q] = 1'b1;
    end
    if (state_q == DONE) done[gnt_q] = 1'b1;
  end

  // State and counter registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pulse_q <= '0;
      minor_q <= '0;
      tank_q  <= '0;
      word_q  <= '0;
      wr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      ack_q   <= '0;
`ifdef TANK_SEQ_RR_ARB_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      minor_q <= minor_d;
      tank_q  <= tank_d;
      word_q  <= word_d;
      wr_q    <= wr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
`ifdef TANK_SEQ_RR_ARB_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.ack       = ack_q;
  assign bus.done      = done;
  assign bus.t_in      = t_in;
  assign bus.t_out     = t_out;
  assign bus.pulse_cnt = pulse_q;
  assign bus.minor_cnt = minor_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_tank_access_sequencer.sv
// Bench for tank_access_sequencer: transaction table plus hand-written
// reset sequences. Timing expectations come from a free-running cycle model.
module tb_tank_access_sequencer;
  localparam int NT  = 4;
  localparam int WPT = 32;
  localparam int WT  = 18;
  localparam int REV = WPT * WT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cyc = 0;
  logic [1:0] exp_q[$];

  tank_access_sequencer_if #(.N_TANKS(NT), .WORDS_PER_TANK(WPT), .WORD_TIME(WT)) bus ();

  tank_access_sequencer #(.N_TANKS(NT), .WORDS_PER_TANK(WPT), .WORD_TIME(WT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Cycle model: cycle index since last reset gives pulse and minor position.
  always @(posedge clk) begin
    if (rst) begin
      m_cyc <= 0;
      exp_q.delete();
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (model cycle %0d)", name, m_cyc);
  endtask

  // Scoreboard and invariants, sampled away from the active edge.
  always @(negedge clk) begin
    logic ok;
    check("pulse_cnt", bus.pulse_cnt, m_cyc % WT);
    check("minor_cnt", bus.minor_cnt, (m_cyc / WT) % WPT);
    ok = $onehot0(bus.t_in) && $onehot0(bus.t_out) && !((|bus.t_in) && (|bus.t_out));
    check("gate_onehot", ok, 1);
    check("ack_done_excl", |(bus.ack & bus.done), 0);
    if (|bus.ack) exp_q.push_back(bus.ack);
    if (|bus.done) begin
      if (exp_q.size() == 0) fail("done_without_ack");
      else check("done_id", bus.done, exp_q.pop_front());
    end
  end

  typedef struct {
    logic [1:0] mask;
    logic [1:0] after;
    logic [1:0] wr;
    logic [1:0] tank0;
    logic [4:0] word0;
    logic [1:0] tank1;
    logic [4:0] word1;
    int         start;
    logic       exp_g;
    logic       scramble;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] mask, input logic [1:0] after,
                              input logic [1:0] wr, input logic [1:0] t0, input logic [4:0] w0,
                              input logic [1:0] t1, input logic [4:0] w1, input int start,
                              input logic g, input logic scr);
    vec_t v;
    v.mask = mask; v.after = after; v.wr = wr;
    v.tank0 = t0; v.word0 = w0; v.tank1 = t1; v.word1 = w1;
    v.start = start; v.exp_g = g; v.scramble = scr;
    return v;
  endfunction

  // Driver: one transaction from the table, checked cycle by cycle to done.
  task automatic run_vec(input vec_t v);
    int waited;
    int ca;
    int s;
    int tk;
    int wd;
    logic wrb;
    logic [1:0] g1h;
    logic [NT-1:0] gate;
    waited = 0;
    while (!(bus.busy == 1'b0 && (v.start < 0 || (m_cyc % REV) == v.start)) && waited < 3 * REV) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 3 * REV) fail("start_wait");
    bus.req_wr   = v.wr;
    bus.req_addr = {v.tank1, v.word1, v.tank0, v.word0};
    bus.req      = v.mask;
    @(negedge clk);
    g1h = v.exp_g ? 2'b10 : 2'b01;
    check("ack", bus.ack, g1h);
    check("busy_granted", bus.busy, 1);
    ca = m_cyc;
    bus.req = v.after;
    if (v.scramble) begin
      bus.req_addr = 14'($urandom);
      bus.req_wr   = 2'($urandom_range(0, 3));
    end
    tk  = v.exp_g ? int'(v.tank1) : int'(v.tank0);
    wd  = v.exp_g ? int'(v.word1) : int'(v.word0);
    wrb = v.wr[v.exp_g];
    s = ca + 1;
    while (!((s % WT) == 0 && ((s / WT) % WPT) == wd)) s++;
    for (int c = ca + 1; c <= s + WT; c++) begin
      @(negedge clk);
      gate = (c >= s && c < s + WT) ? NT'(1) << tk : '0;
      check("t_in",  bus.t_in,  wrb ? gate : '0);
      check("t_out", bus.t_out, wrb ? '0 : gate);
      check("done",  bus.done,  (c == s + WT) ? g1h : 2'b00);
      check("ack_single", bus.ack, 0);
      check("busy", bus.busy, 1);
    end
  endtask

  initial begin
    int waited;
    int ca;
    bus.req = '0;
    bus.req_wr = '0;
    bus.req_addr = '0;

    // Transaction table: mask, req after ack, wr, tank0, word0, tank1, word1, start slot, winner, scramble
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 2'd2, 5'd5,  2'd0, 5'd0,  3,   1'b0, 1'b1));
    vecs.push_back(mk(2'b10, 2'b00, 2'b10, 2'd0, 5'd0,  2'd3, 5'd31, -1,  1'b1, 1'b1));
`ifdef TANK_SEQ_RR_ARB_EN
    vecs.push_back(mk(2'b11, 2'b11, 2'b10, 2'd0, 5'd1,  2'd1, 5'd3,  -1,  1'b0, 1'b0));
    vecs.push_back(mk(2'b11, 2'b11, 2'b10, 2'd0, 5'd1,  2'd1, 5'd3,  -1,  1'b1, 1'b0));
    vecs.push_back(mk(2'b11, 2'b11, 2'b10, 2'd0, 5'd1,  2'd1, 5'd3,  -1,  1'b0, 1'b0));
    vecs.push_back(mk(2'b11, 2'b00, 2'b10, 2'd0, 5'd1,  2'd1, 5'd3,  -1,  1'b1, 1'b0));
`else
    vecs.push_back(mk(2'b11, 2'b10, 2'b10, 2'd0, 5'd1,  2'd1, 5'd3,  -1,  1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 2'b00, 2'b10, 2'd0, 5'd1,  2'd1, 5'd3,  -1,  1'b1, 1'b0));
`endif
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 2'd1, 5'd7,  2'd0, 5'd0,  129, 1'b0, 1'b1));
    vecs.push_back(mk(2'b10, 2'b00, 2'b00, 2'd0, 5'd0,  2'd0, 5'd10, 178, 1'b1, 1'b1));
    vecs.push_back(mk(2'b01, 2'b00, 2'b01, 2'd3, 5'd12, 2'd0, 5'd0,  -1,  1'b0, 1'b1));

    // Reset held three cycles: everything quiet.
    repeat (3) @(negedge clk);
    check("rst_ack",   bus.ack, 0);
    check("rst_done",  bus.done, 0);
    check("rst_t_in",  bus.t_in, 0);
    check("rst_t_out", bus.t_out, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_pulse", bus.pulse_cnt, 0);
    check("rst_minor", bus.minor_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_pulse", bus.pulse_cnt, 1);
    check("post_rst_busy",  bus.busy, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during a write transfer at pulse 9.
    @(negedge clk);
    waited = 0;
    while (bus.busy && waited < 2 * REV) begin @(negedge clk); waited++; end
    if (waited >= 2 * REV) fail("rst_seq_idle");
    bus.req_wr = 2'b01;
    bus.req_addr = {2'd0, 5'd0, 2'd1, 5'd2};
    bus.req = 2'b01;
    @(negedge clk);
    check("rst_seq_ack", bus.ack, 2'b01);
    ca = m_cyc;
    bus.req = 2'b00;
    waited = 0;
    while (!(m_cyc > ca && (m_cyc % WT) == 9 && ((m_cyc / WT) % WPT) == 2) && waited < 2 * REV) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 2 * REV) fail("rst_seq_xfer");
    check("rst_seq_xfer_t_in", bus.t_in, 4'b0010);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_t_in",  bus.t_in, 0);
    check("mid_rst_t_out", bus.t_out, 0);
    check("mid_rst_busy",  bus.busy, 0);
    check("mid_rst_done",  bus.done, 0);
    check("mid_rst_pulse", bus.pulse_cnt, 0);
    check("mid_rst_minor", bus.minor_cnt, 0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("after_rst_done", bus.done, 0);
      check("after_rst_busy", bus.busy, 0);
    end

    // Recovery: a fresh read after the discarded transaction.
    run_vec(mk(2'b01, 2'b00, 2'b00, 2'd0, 5'd4, 2'd0, 5'd0, -1, 1'b0, 1'b1));

    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
